gpu_host_port_ctrl: RTL and testbench

//  Host-side controller for port B (8-bit, host read/write) of the GPU dual-port RAM.

---
 rtl/gpu_host_pkg.sv | 16 +
 rtl/gpu_host_port_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gpu_host_port_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_host_pkg.sv
// Shared types and constants for the GPU host port-B controller.
package gpu_host_pkg;

    localparam int HOST_ADDR_W = 20;
    localparam int HOST_DATA_W = 8;

    localparam logic [HOST_DATA_W-1:0] OOR_RDATA_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/gpu_host_port_ctrl.sv
// Host-side controller for port B of the GPU dual-port RAM: single-byte reads/writes over req/ready.
// Optional feature macro GPU_HOST_AUTO_INC_EN adds ptr_load and an auto-incrementing address pointer.
module gpu_host_port_ctrl
    import gpu_host_pkg::*;
#(
    parameter int ADDR_SIZE    = 14,
    parameter int NUM_WORDS    = 2 ** ADDR_SIZE,
    parameter int READ_LATENCY = 2,
    parameter logic [HOST_DATA_W-1:0] OOR_RDATA = OOR_RDATA_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_req,
    input  logic                   host_wr,
    input  logic [HOST_ADDR_W-1:0] host_addr,
    input  logic [HOST_DATA_W-1:0] host_wdata,
`ifdef GPU_HOST_AUTO_INC_EN
    input  logic                   ptr_load,
`endif
    output logic                   host_ready,
    output logic [HOST_DATA_W-1:0] host_rdata,
    output logic                   host_rvalid,
    output logic [HOST_ADDR_W-1:0] ram_addr_b,
    output logic [HOST_DATA_W-1:0] ram_data_b,
    output logic                   ram_wr_en_b,
    input  logic [HOST_DATA_W-1:0] ram_q_b
);

    localparam int CNT_RAW = $clog2(READ_LATENCY + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    function automatic logic addr_in_range(input logic [HOST_ADDR_W-1:0] a);
        return ({1'b0, a} < (HOST_ADDR_W + 1)'(NUM_WORDS));
    endfunction

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [HOST_ADDR_W-1:0] addr_r, addr_s;
    logic [HOST_DATA_W-1:0] data_r, data_s;
    logic [HOST_DATA_W-1:0] rdata_r, rdata_s;
    logic                   wr_en_r, wr_en_s;
    logic                   rvalid_r, rvalid_s;
    logic                   oor_r, oor_s;
    logic [HOST_ADDR_W-1:0] eff_addr_s;
    logic                   accept_s;
    logic                   in_range_s;

    assign accept_s    = (state_r == IDLE) && host_req;
    assign in_range_s  = addr_in_range(eff_addr_s);

    // Ready and write strobe are gated by reset so both drop in the cycle reset is raised.
    assign host_ready  = (state_r == IDLE) && !reset;
    assign ram_wr_en_b = wr_en_r && !reset;
    assign host_rdata  = rdata_r;
    assign host_rvalid = rvalid_r;
    assign ram_addr_b  = addr_r;
    assign ram_data_b  = data_r;

`ifdef GPU_HOST_AUTO_INC_EN
    logic [HOST_ADDR_W-1:0] ptr_r, ptr_s;

    // Access address: freshly loaded host address or the running pointer.
    always_comb begin
        if (ptr_load) begin
            eff_addr_s = host_addr;
        end else begin
            eff_addr_s = ptr_r;
        end
    end

    // Pointer advances past the address just used, wrapping at the top of the RAM.
    always_comb begin
        ptr_s = ptr_r;
        if (accept_s) begin
            if (eff_addr_s == HOST_ADDR_W'(NUM_WORDS - 1)) begin
                ptr_s = '0;
            end else begin
                ptr_s = eff_addr_s + 20'd1;
            end
        end else begin
            ptr_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_s;
        end
    end
`else
    // Without the pointer every access goes straight to host_addr.
    always_comb begin
        eff_addr_s = host_addr;
    end
`endif

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        addr_s   = addr_r;
        data_s   = data_r;
        rdata_s  = rdata_r;
        oor_s    = oor_r;
        wr_en_s  = 1'b0;
        rvalid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (host_req) begin
                    addr_s = eff_addr_s;
                    oor_s  = !in_range_s;
                    if (host_wr) begin
                        state_s = WRITE;
                        data_s  = host_wdata;
                        wr_en_s = in_range_s;
                    end else begin
                        state_s = RD_WAIT;
                        cnt_s   = '0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                state_s = IDLE;
            end
            RD_WAIT: begin
                // q_b is valid once the counter has covered the RAM's registered latency.
                if (cnt_r == CNT_W'(READ_LATENCY)) begin
                    state_s  = RESP;
                    rvalid_s = 1'b1;
                    rdata_s  = oor_r ? OOR_RDATA : ram_q_b;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            addr_r   <= '0;
            data_r   <= '0;
            rdata_r  <= '0;
            oor_r    <= 1'b0;
            wr_en_r  <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            addr_r   <= addr_s;
            data_r   <= data_s;
            rdata_r  <= rdata_s;
            oor_r    <= oor_s;
            wr_en_r  <= wr_en_s;
            rvalid_r <= rvalid_s;
        end
    end

endmodule

// File: tb/tb_gpu_host_port_ctrl.sv
// Randomized self-checking bench for gpu_host_port_ctrl with a transaction-level reference model and RAM model.
module tb_gpu_host_port_ctrl;
    import gpu_host_pkg::*;

    localparam int RL = 2;
    localparam int NW = 16384;

    logic        clk = 1'b0;
    logic        reset, host_req, host_wr, ptr_load;
    logic [19:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ready, host_rvalid, ram_wr_en_b;
    logic [7:0]  host_rdata, ram_data_b, ram_q_b;
    logic [19:0] ram_addr_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpu_host_port_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
`ifdef GPU_HOST_AUTO_INC_EN
        .ptr_load   (ptr_load),
`endif
        .host_ready (host_ready),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_wr_en_b(ram_wr_en_b),
        .ram_q_b    (ram_q_b)
    );

    // RAM port B: address register then output register (two edges of latency).
    logic [7:0]  ram_mem [NW];
    logic [13:0] ram_a_q;
    always @(posedge clk) begin
        if (ram_wr_en_b) ram_mem[ram_addr_b[13:0]] <= ram_data_b;
        ram_a_q <= ram_addr_b[13:0];
        ram_q_b <= ram_mem[ram_a_q];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by the cycles its effects appear in.
    logic [7:0]  ref_mem [NW];
    longint      cyc = 0, free_at = 0, wr_at = -1, rv_at = -1;
    logic        wr_ok = 1'b0;
    logic [19:0] addr_e = '0, ptr_m = '0, eff;
    logic [7:0]  data_e = '0, rdata_e = '0, rd_pend = '0;
    logic        ready_e, wr_e, rv_e;
    bit          chk_en = 1'b0;

    always @(negedge clk) begin
        wr_e = 1'b0;
        if (chk_en) begin
            if (cyc == rv_at) rdata_e = rd_pend;
            ready_e = (cyc >= free_at) && !reset;
            wr_e    = (cyc == wr_at) && wr_ok && !reset;
            rv_e    = (cyc == rv_at);
            chk("host_ready",  32'(host_ready),  32'(ready_e));
            chk("ram_wr_en_b", 32'(ram_wr_en_b), 32'(wr_e));
            chk("host_rvalid", 32'(host_rvalid), 32'(rv_e));
            chk("host_rdata",  32'(host_rdata),  32'(rdata_e));
            chk("ram_addr_b",  32'(ram_addr_b),  32'(addr_e));
            chk("ram_data_b",  32'(ram_data_b),  32'(data_e));
            if (wr_e) ref_mem[addr_e[13:0]] = data_e;
        end
        if (reset) begin
            chk_en  = 1'b1;
            addr_e  = '0;
            data_e  = '0;
            rdata_e = '0;
            ptr_m   = '0;
            wr_at   = -1;
            rv_at   = -1;
            free_at = cyc + 1;
        end else if (chk_en && host_req && cyc >= free_at) begin
`ifdef GPU_HOST_AUTO_INC_EN
            eff   = ptr_load ? host_addr : ptr_m;
            ptr_m = (eff == 20'(NW - 1)) ? 20'd0 : eff + 20'd1;
`else
            eff   = host_addr;
`endif
            addr_e = eff;
            if (host_wr) begin
                data_e  = host_wdata;
                wr_at   = cyc + 1;
                wr_ok   = (eff < 20'(NW));
                free_at = cyc + 2;
            end else begin
                rd_pend = (eff < 20'(NW)) ? ref_mem[eff[13:0]] : 8'hFF;
                rv_at   = cyc + 2 + RL;
                free_at = cyc + 3 + RL;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic w, input logic [19:0] a, input logic [7:0] d, input logic l);
        host_req = r; host_wr = w; host_addr = a; host_wdata = d; ptr_load = l;
    endtask

    // Issue a read in the current cycle and report when (and with what data) host_rvalid appears.
    task automatic do_read(input logic [19:0] a, output int lat, output logic [7:0] dat);
        lat = 0;
        dat = 8'h00;
        drv(1'b1, 1'b0, a, 8'h00, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) drv(1'b0, 1'b0, 20'h0, 8'h00, 1'b0);
            @(negedge clk);
            if (host_rvalid && lat == 0) begin
                lat = k;
                dat = host_rdata;
            end
        end
    endtask

    initial begin
        int lat, seen;
        logic [7:0] dat;
        logic [19:0] a;
        for (int i = 0; i < NW; i++) begin
            ram_mem[i] = 8'(i * 13 + 7);
            ref_mem[i] = 8'(i * 13 + 7);
        end
        reset = 1'b1;
        drv(1'b0, 1'b0, 20'h0, 8'h00, 1'b0);
        step(); step();
        @(negedge clk);
        chk("reset_ready_low", 32'(host_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("release_ready", 32'(host_ready), 32'd1);
        chk("release_wren",  32'(ram_wr_en_b), 32'd0);

        // Write 0x5A to 0x0123.
        step();
        drv(1'b1, 1'b1, 20'h00123, 8'h5A, 1'b1);
        step();
        drv(1'b0, 1'b0, 20'h0, 8'h00, 1'b0);
        @(negedge clk);
        chk("wr_c1_wren",  32'(ram_wr_en_b), 32'd1);
        chk("wr_c1_addr",  32'(ram_addr_b),  32'h00123);
        chk("wr_c1_data",  32'(ram_data_b),  32'h5A);
        chk("wr_c1_ready", 32'(host_ready),  32'd0);
        step();
        @(negedge clk);
        chk("wr_c2_wren",  32'(ram_wr_en_b), 32'd0);
        chk("wr_c2_ready", 32'(host_ready),  32'd1);

        // Read it back.
        step();
        do_read(20'h00123, lat, dat);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_data",    32'(dat), 32'h5A);

        // Out-of-range write is dropped, out-of-range read returns 0xFF.
        step();
        drv(1'b1, 1'b1, 20'h04000, 8'h77, 1'b1);
        step();
        drv(1'b0, 1'b0, 20'h0, 8'h00, 1'b0);
        @(negedge clk);
        chk("oor_wr_wren", 32'(ram_wr_en_b), 32'd0);
        step(); step();
        do_read(20'h04000, lat, dat);
        chk("oor_rd_latency", 32'(lat), 32'd4);
        chk("oor_rd_data",    32'(dat), 32'hFF);

        // Reset in cycle 2 of a read aborts it.
        step();
        drv(1'b1, 1'b0, 20'h00123, 8'h00, 1'b1);
        step();
        drv(1'b0, 1'b0, 20'h0, 8'h00, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(host_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (host_rvalid) seen++;
            step();
            @(negedge clk);
        end
        chk("abort_no_rvalid", 32'(seen), 32'd0);

`ifdef GPU_HOST_AUTO_INC_EN
        // Pointer load at the top of the RAM, then wrap to zero; a request during WRITE is ignored.
        step();
        drv(1'b1, 1'b1, 20'h03FFF, 8'h11, 1'b1);
        step();
        drv(1'b1, 1'b1, 20'h00200, 8'h99, 1'b1);
        @(negedge clk);
        chk("ai_w1_wren", 32'(ram_wr_en_b), 32'd1);
        chk("ai_w1_addr", 32'(ram_addr_b),  32'h03FFF);
        chk("ai_w1_data", 32'(ram_data_b),  32'h11);
        step();
        drv(1'b1, 1'b1, 20'h00555, 8'h22, 1'b0);
        step();
        drv(1'b0, 1'b0, 20'h0, 8'h00, 1'b0);
        @(negedge clk);
        chk("ai_w2_wren", 32'(ram_wr_en_b), 32'd1);
        chk("ai_w2_addr", 32'(ram_addr_b),  32'h00000);
        chk("ai_w2_data", 32'(ram_data_b),  32'h22);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            step();
            case ($urandom % 4)
                0: a = 20'($urandom_range(0, 15));
                1: a = 20'($urandom_range(0, NW - 1));
                2: a = 20'($urandom_range(NW, 20'hFFFFF));
                default: a = 20'(NW - 1 - $urandom_range(0, 2));
            endcase
            drv(1'($urandom % 2), 1'($urandom % 2), a, 8'($urandom), 1'($urandom % 2));
            reset = ($urandom % 64 == 0);
        end
        step();
        reset = 1'b0;
        drv(1'b0, 1'b0, 20'h0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) step();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
